// File: rtl/fric_switch_nport.sv
// FRIC switch: one master port fanned out to NPORTS slave ports,
// with response timeout, request rejection and status outputs.
module fric_switch_nport #(
    parameter int NPORTS  = 7,
    parameter int TIMEOUT = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            fric_in0,
    output logic [7:0]            fric_out0,
    input  logic [8*NPORTS-1:0]   fric_in_s,
    output logic [8*NPORTS-1:0]   fric_out_s,
    output logic                  busy,
    output logic                  err_pulse,
    output logic [1:0]            err_code
);

    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [3:0] {
        IDLE,
        REQ_ADR,
        WDAT0,
        WDAT1,
        WACK,
        REP_ADR,
        RDAT0,
        RDAT1,
        ERR0,
        ERR1
    } state_t;

    state_t state, nxt;

    logic [7:0]          inr0;
    logic [8*NPORTS-1:0] inr_s;
    logic [3:0]          psel, psel_n;
    logic [3:0]          typ, typ_n;
    logic [CW-1:0]       cnt, cnt_n, cnt_inc;

    logic [7:0]          rep;
    logic [7:0]          fwd;
    logic [3:0]          fsel;
    logic [7:0]          out0_n;
    logic [8*NPORTS-1:0] outs_n;
    logic                pulse_n;
    logic [1:0]          code_n;
    logic                bad_port;
    logic                ill_type;

    assign cnt_inc  = cnt + CW'(1);
    assign bad_port = (inr0[3:0] == 4'd0) ||
                      (int'(inr0[3:0]) > NPORTS);
    assign ill_type = (inr0[7:4] != 4'd2) &&
                      (inr0[7:4] != 4'd3);

    // Only the selected slave's lane is ever looked at.
    always_comb begin
        rep = 8'h00;
        for (int k = 0; k < NPORTS; k++) begin
            if (psel == 4'(k + 1)) rep = inr_s[8*k +: 8];
        end
    end

    always_comb begin
        nxt     = state;
        psel_n  = psel;
        typ_n   = typ;
        cnt_n   = '0;
        out0_n  = 8'h00;
        fwd     = 8'h00;
        fsel    = psel;
        pulse_n = 1'b0;
        code_n  = err_code;
        unique case (state)
            IDLE: begin
                if (inr0[7:4] != 4'd0) begin
                    psel_n = inr0[3:0];
                    typ_n  = inr0[7:4];
                    fsel   = inr0[3:0];
                    if (bad_port || ill_type) begin
                        nxt     = ERR0;
                        pulse_n = 1'b1;
                        code_n  = bad_port ? 2'd2 : 2'd3;
                        out0_n  = {4'hF, inr0[3:0]};
                    end else begin
                        nxt = REQ_ADR;
                        fwd = {inr0[7:4], 4'h0};
                    end
                end
            end
            REQ_ADR: begin
                fwd = inr0;
                nxt = (typ == 4'd2) ? WDAT0 : WACK;
            end
            WDAT0: begin
                fwd = inr0;
                nxt = WDAT1;
            end
            WDAT1: begin
                fwd = inr0;
                nxt = WACK;
            end
            // A reply header beats a timeout landing on the same cycle.
            WACK: begin
                if (rep[7:4] != 4'd0) begin
                    out0_n = {rep[7:4], psel};
                    nxt    = REP_ADR;
                end else if (cnt_inc == CW'(TIMEOUT)) begin
                    out0_n  = {4'hF, psel};
                    pulse_n = 1'b1;
                    code_n  = 2'd1;
                    nxt     = ERR0;
                end else begin
                    cnt_n = cnt_inc;
                end
            end
            REP_ADR: begin
                out0_n = rep;
                nxt    = (typ == 4'd2) ? IDLE : RDAT0;
            end
            RDAT0: begin
                out0_n = rep;
                nxt    = RDAT1;
            end
            RDAT1: begin
                out0_n = rep;
                nxt    = IDLE;
            end
            ERR0: nxt = ERR1;
            ERR1: nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    always_comb begin
        outs_n = '0;
        for (int k = 0; k < NPORTS; k++) begin
            if (fsel == 4'(k + 1)) outs_n[8*k +: 8] = fwd;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            psel       <= 4'd0;
            typ        <= 4'd0;
            cnt        <= '0;
            inr0       <= 8'h00;
            inr_s      <= '0;
            fric_out0  <= 8'h00;
            fric_out_s <= '0;
            busy       <= 1'b0;
            err_pulse  <= 1'b0;
            err_code   <= 2'd0;
        end else begin
            state      <= nxt;
            psel       <= psel_n;
            typ        <= typ_n;
            cnt        <= cnt_n;
            inr0       <= fric_in0;
            inr_s      <= fric_in_s;
            fric_out0  <= out0_n;
            fric_out_s <= outs_n;
            busy       <= (nxt != IDLE);
            err_pulse  <= pulse_n;
            err_code   <= code_n;
        end
    end

endmodule

// File: tb/tb_fric_switch_nport.sv
// Scoreboard bench for fric_switch_nport at NPORTS = 7, 15 and 1.
// Expected words carry the cycle on which they must appear.
module tb_fric_switch_nport;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_err = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0]   mi_a = '0, mi_b = '0, mi_c = '0;
    logic [7:0]   mo_a, mo_b, mo_c;
    logic [55:0]  si_a = '0;
    logic [119:0] si_b = '0;
    logic [7:0]   si_c = '0;
    logic [55:0]  so_a;
    logic [119:0] so_b;
    logic [7:0]   so_c;
    logic         bz_a, bz_b, bz_c;
    logic         ep_a, ep_b, ep_c;
    logic [1:0]   ec_a, ec_b, ec_c;

    fric_switch_nport #(.NPORTS(7), .TIMEOUT(5)) u_a (
        .clk(clk), .rst(rst),
        .fric_in0(mi_a), .fric_out0(mo_a),
        .fric_in_s(si_a), .fric_out_s(so_a),
        .busy(bz_a), .err_pulse(ep_a), .err_code(ec_a)
    );

    fric_switch_nport #(.NPORTS(15), .TIMEOUT(255)) u_b (
        .clk(clk), .rst(rst),
        .fric_in0(mi_b), .fric_out0(mo_b),
        .fric_in_s(si_b), .fric_out_s(so_b),
        .busy(bz_b), .err_pulse(ep_b), .err_code(ec_b)
    );

    fric_switch_nport #(.NPORTS(1), .TIMEOUT(8)) u_c (
        .clk(clk), .rst(rst),
        .fric_in0(mi_c), .fric_out0(mo_c),
        .fric_in_s(si_c), .fric_out_s(so_c),
        .busy(bz_c), .err_pulse(ep_c), .err_code(ec_c)
    );

    typedef struct {
        int         d;
        int         lane;
        int         cyc;
        logic [7:0] v;
    } exp_t;

    exp_t sb[$];

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic void push(int d, int lane, int c,
                                 logic [7:0] v);
        exp_t e;
        e.d = d; e.lane = lane; e.cyc = c; e.v = v;
        sb.push_back(e);
    endfunction

    function automatic logic [7:0] get_m(int d);
        return (d == 0) ? mo_a : (d == 1) ? mo_b : mo_c;
    endfunction

    function automatic logic [119:0] get_s(int d);
        return (d == 0) ? {64'b0, so_a} :
               (d == 1) ? so_b : {112'b0, so_c};
    endfunction

    function automatic logic get_bz(int d);
        return (d == 0) ? bz_a : (d == 1) ? bz_b : bz_c;
    endfunction

    function automatic logic get_ep(int d);
        return (d == 0) ? ep_a : (d == 1) ? ep_b : ep_c;
    endfunction

    function automatic logic [1:0] get_ec(int d);
        return (d == 0) ? ec_a : (d == 1) ? ec_b : ec_c;
    endfunction

    task automatic set_m(int d, logic [7:0] v);
        case (d)
            0: mi_a = v;
            1: mi_b = v;
            default: mi_c = v;
        endcase
    endtask

    task automatic set_s(int d, int p, logic [7:0] v);
        case (d)
            0: si_a[p*8-8 +: 8] = v;
            1: si_b[p*8-8 +: 8] = v;
            default: si_c = v;
        endcase
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic match(int d, int l, logic [7:0] v);
        int idx = -1;
        foreach (sb[i])
            if (idx < 0 && sb[i].d == d && sb[i].lane == l) idx = i;
        if (idx < 0) begin
            chk($sformatf("unexp d%0d lane%0d @%0d", d, l, cyc),
                {24'b0, v}, 32'h0);
        end else begin
            chk($sformatf("val d%0d lane%0d", d, l),
                {24'b0, v}, {24'b0, sb[idx].v});
            chk($sformatf("cyc d%0d lane%0d", d, l),
                cyc, sb[idx].cyc);
            sb.delete(idx);
        end
    endtask

    always @(negedge clk) begin : mon
        logic [7:0]   v;
        logic [119:0] s;
        for (int d = 0; d < 3; d++) begin
            v = get_m(d);
            if (v != 8'h00) match(d, 0, v);
            s = get_s(d);
            for (int l = 1; l < 16; l++) begin
                v = s[l*8-8 +: 8];
                if (v != 8'h00) match(d, l, v);
            end
        end
    end

    task automatic wr(int d, int p, logic [7:0] a,
                      logic [7:0] w0, logic [7:0] w1);
        int c = cyc;
        push(d, p, c + 2, 8'h20);
        push(d, p, c + 3, a);
        push(d, p, c + 4, w0);
        push(d, p, c + 5, w1);
        push(d, 0, c + 8, {4'h2, 4'(p)});
        push(d, 0, c + 9, a);
        for (int i = 0; i <= 12; i++) begin
            if (i == 8) chk("wr_busy_hi", get_bz(d), 1);
            if (i == 10) chk("wr_busy_lo", get_bz(d), 0);
            case (i)
                0: set_m(d, {4'h2, 4'(p)});
                1: set_m(d, a);
                2: set_m(d, w0);
                3: set_m(d, w1);
                default: set_m(d, 8'h00);
            endcase
            case (i)
                6: set_s(d, p, 8'h20);
                7: set_s(d, p, a);
                default: set_s(d, p, 8'h00);
            endcase
            tick();
        end
    endtask

    task automatic rd(int d, int p, logic [7:0] a,
                      logic [7:0] w0, logic [7:0] w1, int rc);
        int c = cyc;
        push(d, p, c + 2, 8'h30);
        push(d, p, c + 3, a);
        push(d, 0, c + rc + 2, {4'h3, 4'(p)});
        push(d, 0, c + rc + 3, a);
        push(d, 0, c + rc + 4, w0);
        push(d, 0, c + rc + 5, w1);
        for (int i = 0; i <= rc + 7; i++) begin
            if (i == rc + 2) chk("rd_no_err", get_ep(d), 0);
            if (i == rc + 4) chk("rd_busy_hi", get_bz(d), 1);
            if (i == rc + 6) chk("rd_busy_lo", get_bz(d), 0);
            if (i == 0) set_m(d, {4'h3, 4'(p)});
            else if (i == 1) set_m(d, a);
            else set_m(d, 8'h00);
            if (i == rc) set_s(d, p, 8'h30);
            else if (i == rc + 1) set_s(d, p, a);
            else if (i == rc + 2) set_s(d, p, w0);
            else if (i == rc + 3) set_s(d, p, w1);
            else set_s(d, p, 8'h00);
            tick();
        end
    endtask

    task automatic tmo(int d, int p, logic [7:0] a, int to);
        int c = cyc;
        push(d, p, c + 2, 8'h30);
        push(d, p, c + 3, a);
        push(d, 0, c + 3 + to, {4'hF, 4'(p)});
        for (int i = 0; i <= to + 6; i++) begin
            if (i == to + 3) begin
                chk("to_pulse", get_ep(d), 1);
                chk("to_code", get_ec(d), 1);
            end
            if (i == to + 4) chk("to_pulse_end", get_ep(d), 0);
            if (i == 0) set_m(d, {4'h3, 4'(p)});
            else if (i == 1) set_m(d, a);
            else set_m(d, 8'h00);
            tick();
        end
    endtask

    task automatic bad(int d, logic [7:0] h, logic [1:0] code);
        int c = cyc;
        push(d, 0, c + 2, {4'hF, h[3:0]});
        for (int i = 0; i <= 6; i++) begin
            if (i == 2) begin
                chk("bad_pulse", get_ep(d), 1);
                chk("bad_code", get_ec(d), code);
                chk("bad_busy", get_bz(d), 1);
            end
            if (i == 3) chk("bad_pulse_end", get_ep(d), 0);
            if (i == 5) chk("bad_idle", get_bz(d), 0);
            set_m(d, (i == 0) ? h : 8'h00);
            tick();
        end
    endtask

    task automatic rst_mid();
        int c = cyc;
        logic [119:0] s;
        push(0, 3, c + 2, 8'h20);
        push(0, 3, c + 3, 8'h40);
        for (int i = 0; i <= 6; i++) begin
            if (i == 4) begin
                s = get_s(0);
                chk("rst_busy", get_bz(0), 0);
                chk("rst_out0", get_m(0), 0);
                chk("rst_outs", s, 0);
                chk("rst_code", get_ec(0), 0);
                chk("rst_pulse", get_ep(0), 0);
            end
            case (i)
                0: set_m(0, 8'h23);
                1: set_m(0, 8'h40);
                2: set_m(0, 8'hAA);
                default: set_m(0, 8'h00);
            endcase
            rst = (i == 3);
            tick();
        end
    endtask

    initial begin
        rst = 1'b1;
        repeat (3) tick();
        for (int d = 0; d < 3; d++) begin
            chk("reset_out0", get_m(d), 0);
            chk("reset_outs", get_s(d), 0);
            chk("reset_busy", get_bz(d), 0);
            chk("reset_code", {get_ep(d), get_ec(d)}, 0);
        end
        rst = 1'b0;
        tick();

        wr(0, 3, 8'h40, 8'hAA, 8'h55);
        rd(0, 7, 8'h10, 8'hDE, 8'hAD, 4);
        tmo(0, 2, 8'h10, 5);
        rd(0, 2, 8'h10, 8'hDE, 8'hAD, 6);
        chk("code_held", get_ec(0), 1);
        bad(0, 8'h20, 2);
        bad(0, 8'h29, 2);
        bad(0, 8'h53, 3);
        rst_mid();
        rd(0, 1, 8'h11, 8'h5A, 8'hA5, 4);

        wr(1, 15, 8'h44, 8'h12, 8'h34);
        rd(1, 15, 8'h20, 8'hBE, 8'hEF, 5);
        rd(1, 1, 8'h10, 8'hDE, 8'hAD, 4);

        wr(2, 1, 8'h40, 8'hAA, 8'h55);
        rd(2, 1, 8'h10, 8'hDE, 8'hAD, 4);
        bad(2, 8'h22, 2);

        repeat (4) tick();
        chk("sb_left", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors",
                 n_chk, n_err);
        $finish;
    end

endmodule
